// File: rtl/wm_pkg.sv
// Shared constants for the wash/dry countdown chain: state encoding, default
// pricing, credit limit and BCD digit width.
package wm_pkg;

    localparam int BCD_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CREDIT = 2'd1;
    localparam logic [1:0] ST_LOAD   = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam int DEF_DEBOUNCE_CYCLES     = 1000000;
    localparam int DEF_MAX_DOLLARS         = 3;
    localparam int DEF_WASH_MIN_PER_DOLLAR = 10;
    localparam int DEF_DRY_MIN_PER_DOLLAR  = 15;

    // Two BCD digits of minutes can show at most 59 on the countdown display.
    localparam int MAX_PRESET_MINUTES = 59;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: two-flop synchronizer, consecutive-sample
// debounce filter and a one-cycle press pulse on the filtered rising edge.
module btn_debounce
    import wm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $fatal(1, "btn_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_dly_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample that agrees with the filtered level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // The input path comes out of reset as "pressed" so a button held through
    // reset has to be released and pressed again before it produces a pulse.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            pulse_q     <= level_q & ~level_dly_q;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/credit_load_ctrl.sv
// Front-panel credit controller: debounced buttons build a dollar credit, start
// converts it to a BCD minute preset handed to the countdown over valid/ready.
module credit_load_ctrl
    import wm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int MAX_DOLLARS         = DEF_MAX_DOLLARS,
    parameter int WASH_MIN_PER_DOLLAR = DEF_WASH_MIN_PER_DOLLAR,
    parameter int DRY_MIN_PER_DOLLAR  = DEF_DRY_MIN_PER_DOLLAR
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             BTNU,
    input  logic             BTND,
    input  logic             BTNC,
    input  logic [5:0]       SW,
    output logic             load_valid,
    input  logic             load_ready,
    output logic [BCD_W-1:0] load_tens,
    output logic [BCD_W-1:0] load_ones,
    input  logic             timer_done,
    output logic [3:0]       credit,
    output logic             busy,
    output logic [1:0]       state
);

    localparam int MAX_RATE = max_int(WASH_MIN_PER_DOLLAR, DRY_MIN_PER_DOLLAR);
    localparam logic [3:0] MAX_CREDIT = 4'(MAX_DOLLARS);

    if (MAX_DOLLARS * MAX_RATE > MAX_PRESET_MINUTES) begin : g_bad_minutes
        $fatal(1, "credit_load_ctrl: MAX_DOLLARS * rate exceeds two BCD digits of minutes");
    end
    if (MAX_DOLLARS < 1 || MAX_DOLLARS > 15) begin : g_bad_credit
        $fatal(1, "credit_load_ctrl: MAX_DOLLARS must fit the 4-bit credit display (1..15)");
    end

    function automatic logic [5:0] minutes_for(input logic [3:0] dollars, input logic dry);
        int rate;
        rate = dry ? DRY_MIN_PER_DOLLAR : WASH_MIN_PER_DOLLAR;
        return 6'(int'(dollars) * rate);
    endfunction

    function automatic logic [2*BCD_W-1:0] to_bcd(input logic [5:0] minutes);
        return {BCD_W'(minutes / 6'd10), BCD_W'(minutes % 6'd10)};
    endfunction

    logic up_pulse;
    logic dn_pulse;
    logic start_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .btn_raw    (BTNU),
        .press_pulse(up_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .btn_raw    (BTND),
        .press_pulse(dn_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .btn_raw    (BTNC),
        .press_pulse(start_pulse)
    );

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [3:0]         credit_q;
    logic [3:0]         credit_d;
    logic               load_valid_q;
    logic               load_valid_d;
    logic [BCD_W-1:0]   tens_q;
    logic [BCD_W-1:0]   tens_d;
    logic [BCD_W-1:0]   ones_q;
    logic [BCD_W-1:0]   ones_d;
    logic [5:0]         preset_minutes;
    logic [2*BCD_W-1:0] preset_bcd;
    logic               unused_sw;

    // Only the wash/dry select is meaningful; the other switches are spare.
    assign unused_sw      = ^SW[5:1];
    assign preset_minutes = minutes_for(credit_q, SW[0]);
    assign preset_bcd     = to_bcd(preset_minutes);

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        load_valid_d = load_valid_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                // Start takes priority and uses the credit as it stood before
                // any simultaneous up/down press.
                if (state_q == ST_CREDIT && start_pulse) begin
                    tens_d       = preset_bcd[2*BCD_W-1:BCD_W];
                    ones_d       = preset_bcd[BCD_W-1:0];
                    load_valid_d = 1'b1;
                    state_d      = ST_LOAD;
                end else if (up_pulse && !dn_pulse) begin
                    if (credit_q < MAX_CREDIT) begin
                        credit_d = credit_q + 4'd1;
                    end
                    state_d = ST_CREDIT;
                end else if (dn_pulse && !up_pulse) begin
                    if (credit_q != 4'd0) begin
                        credit_d = credit_q - 4'd1;
                    end
                    state_d = (credit_q > 4'd1) ? ST_CREDIT : ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_ready) begin
                    load_valid_d = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (timer_done) begin
                    credit_d = 4'd0;
                    tens_d   = '0;
                    ones_d   = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q      <= ST_IDLE;
            credit_q     <= 4'd0;
            load_valid_q <= 1'b0;
            tens_q       <= '0;
            ones_q       <= '0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            load_valid_q <= load_valid_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
        end
    end

    assign load_valid = load_valid_q;
    assign load_tens  = tens_q;
    assign load_ones  = ones_q;
    assign credit     = credit_q;
    assign state      = state_q;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN);

endmodule

// File: doc/credit_load_ctrl.md
Name: credit_load_ctrl

Overview:
- Front-end "writer" for the wash/dry countdown chain: turns raw front-panel buttons into a validated dollar credit.
- On start, converts the credit to a BCD minute preset and delivers it to the minute/ten-minute down-counters over a valid/ready load handshake.
- After delivery it locks the panel until the counters report expiry.
- Sits between the board pins (BTNU/BTND/BTNC/SW) and the countdown counters and display mux.

Parameters:
- DEBOUNCE_CYCLES, 1000000: stable-level cycles needed before a button press is accepted (10 ms at 100 MHz).
- MAX_DOLLARS, 3: credit saturation limit.
- WASH_MIN_PER_DOLLAR, 10: minutes bought per dollar when SW[0]=0.
- DRY_MIN_PER_DOLLAR, 15: minutes bought per dollar when SW[0]=1.

Ports:
- CLK100MHZ, in, 1: single system clock.
- CPU_RESETN, in, 1: asynchronous, active-low reset.
- BTNU, in, 1: raw button, add one dollar.
- BTND, in, 1: raw button, remove one dollar.
- BTNC, in, 1: raw button, start cycle.
- SW, in, 6: mode switches; SW[0] is wash(0)/dry(1); SW[5:1] reserved and ignored.
- load_valid, out, 1: preset offered to the counters.
- load_ready, in, 1: counters accept the preset this cycle.
- load_tens, out, 4: BCD tens of minutes, range 0..5.
- load_ones, out, 4: BCD ones of minutes, range 0..9.
- timer_done, in, 1: one-cycle pulse; countdown reached 00.
- credit, out, 4: current dollars, for the display digit.
- busy, out, 1: high in LOAD and RUN.
- state, out, 2: IDLE=0, CREDIT=1, LOAD=2, RUN=3, for LEDs.

Behaviour:
- Reset (async assert, sync release) clears everything: state=IDLE, credit=0, load_valid=0, load_tens=0, load_ones=0, busy=0, all debounce counters and pulse flags 0.
- Button path, per button: 2-flop synchronizer, then debounce counter.
  - The filtered level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - A rising edge of the filtered level produces a 1-cycle press pulse.
  - Press pulse latency from a clean input edge is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Credit update happens only in IDLE/CREDIT:
  - Up pulse: credit+1, saturating at MAX_DOLLARS.
  - Down pulse: credit-1, saturating at 0.
  - Up and down pulses in the same cycle: no change.
  - The state becomes CREDIT when the new credit is >0 and IDLE when it is 0.
- Start pulse:
  - In IDLE: ignored.
  - In CREDIT, next cycle:
    - minutes = credit * (SW[0] ? DRY : WASH), with SW[0] sampled on that start cycle only.
    - load_tens = minutes/10 and load_ones = minutes%10 are registered.
    - load_valid=1 and state becomes LOAD.
  - Start in the same cycle as an up/down pulse: start wins; the credit used is the pre-update value.
- LOAD:
  - load_valid, load_tens and load_ones are held stable until sampled with load_ready=1.
  - In the cycle after acceptance: load_valid=0 and state becomes RUN.
  - load_ready while load_valid=0 is ignored.
- RUN:
  - All button pulses and SW changes are ignored.
  - timer_done causes, next cycle: credit=0, load_tens=0, load_ones=0, state=IDLE.
  - timer_done outside RUN is ignored.
- busy is 1 exactly when state is LOAD or RUN.
- Reset mid-LOAD or mid-RUN: immediate return to reset values; the counters are told nothing further.
- Width rules:
  - minutes is at most MAX_DOLLARS*max(rate), which must be ≤59; this is a static elaboration check, otherwise fatal.
  - The debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits wide.

Decomposition:
- Shared package wm_pkg: state encoding constants (ST_IDLE/ST_CREDIT/ST_LOAD/ST_RUN), default rates, MAX_DOLLARS, and the BCD digit width (4).
- Sub-module btn_debounce, parameterised by DEBOUNCE_CYCLES:
  - ports CLK100MHZ, CPU_RESETN, btn_raw, press_pulse;
  - instantiated 3 times.
- The FSM, credit register and BCD preset logic live in the top.

Test Plan:
- Run with DEBOUNCE_CYCLES=4.
- Reset while BTNU is held high -> all outputs 0, state=0; no pulse until BTNU is released and pressed again.
- BTNU pressed 5 clean times -> credit 1,2,3,3,3; state=1; one BTND press -> credit=2.
- BTNU bouncing (1-0-1 at 2-cycle spacing), then stable for 4 cycles -> exactly one credit increment, 7 cycles after the stable edge.
- Credit=3, SW[0]=1, BTNC, load_ready held 0 for 5 cycles -> load_valid=1, load_tens=4, load_ones=5 stable throughout; load_ready=1 -> next cycle load_valid=0, state=3.
- In RUN: BTNU/BTND/BTNC pressed and SW[0] toggled -> credit and load digits unchanged; timer_done pulse -> next cycle state=0, credit=0, busy=0.
- Credit=2, SW[0]=0, start -> preset 2/0; assert CPU_RESETN low mid-LOAD -> load_valid drops to 0 asynchronously, state=0. Also: BTNC with credit=0 -> no load_valid ever asserted.
